// File: rtl/hex_display_mmio.sv
// Memory-mapped 7-digit decimal display: a store to BASE_ADDR is converted to BCD by
// a 24-cycle double-dabble and latched onto HEX0..HEX6. Optional macro: HEX_LEADING_ZERO_BLANK_EN.
module hex_display_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0404
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic [31:0] rd_data,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6
);

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [23:0] DASH_MIN  = 24'd10_000_000;

  state_t           state_q, state_d;
  logic [23:0]      shift_q, shift_d;
  logic [27:0]      bcd_q, bcd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             pend_q, pend_d;
  logic [23:0]      pend_data_q, pend_data_d;
  logic [6:0][6:0]  hex_q, hex_d;

  logic             accept;
  logic             busy;
  logic [27:0]      bcd_adj;
  logic [6:0][6:0]  disp;
  logic [23:0]      load_val;
  logic             unused_wdata;

  assign accept       = mem_write && (alu_result == BASE_ADDR);
  assign busy         = (state_q == CONVERT) || (state_q == LATCH);
  assign unused_wdata = ^write_data[31:24];
  assign rd_data      = (alu_result == STAT_ADDR) ? {30'b0, pend_q, busy} : 32'b0;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  for (genvar gi = 0; gi < 7; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < 7; i++) begin
      disp[i] = over_q ? SEG_DASH : seg(bcd_q[4*i +: 4]);
    end
`ifdef HEX_LEADING_ZERO_BLANK_EN
    // HEX0 always shows a digit; only numeric results lose their leading zeros.
    for (int i = 6; i >= 1; i--) begin
      nz = nz || (bcd_q[4*i +: 4] != 4'd0);
      if (!over_q && !nz) disp[i] = SEG_BLANK;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    over_d      = over_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    hex_d       = hex_q;
    load_val    = accept ? write_data[23:0] : pend_data_q;

    case (state_q)
      IDLE: begin
        if (accept || pend_q) begin
          shift_d = load_val;
          bcd_d   = 28'b0;
          cnt_d   = 5'd0;
          over_d  = (load_val >= DASH_MIN);
          pend_d  = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (accept) begin
          pend_d      = 1'b1;
          pend_data_d = write_data[23:0];
        end
        bcd_d   = {bcd_adj[26:0], shift_q[23]};
        shift_d = {shift_q[22:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = LATCH;
      end
      LATCH: begin
        if (accept) begin
          pend_d      = 1'b1;
          pend_data_d = write_data[23:0];
        end
        hex_d   = disp;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= 24'b0;
      bcd_q       <= 28'b0;
      cnt_q       <= 5'd0;
      over_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 24'b0;
      hex_q       <= {7{SEG_BLANK}};
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      over_q      <= over_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      hex_q       <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];

endmodule

// File: tb/tb_hex_display_mmio.sv
// Self-checking bench for hex_display_mmio: display updates are scoreboarded against a
// decimal model, and status/timing are checked inline per scenario.
module tb_hex_display_mmio;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] STAT = 32'h0000_0404;
  localparam logic [48:0] ALL_BLANK = {7{7'b1111111}};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] alu_result = 32'b0;
  logic [31:0] write_data = 32'b0;
  logic [31:0] rd_data;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6;
  logic [48:0] hex_bus;

  int passed = 0;
  int total  = 0;

  logic [48:0] exp_q[$];
  logic [48:0] last_hex = ALL_BLANK;
  bit          mon_en = 1'b0;

  assign hex_bus = {HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  hex_display_mmio dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .alu_result(alu_result),
    .write_data(write_data), .rd_data(rd_data),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_model(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [48:0] disp_model(input int v);
    logic [48:0] r;
    int dig[7];
    int t;
    bit nz;
    if (v >= 10_000_000) return {7{7'b0111111}};
    t = v;
    for (int i = 0; i < 7; i++) begin
      dig[i] = t % 10;
      t = t / 10;
    end
    nz = 1'b0;
    r = '0;
    for (int i = 6; i >= 0; i--) begin
      nz = nz || (dig[i] != 0);
      r[7*i +: 7] = seg_model(dig[i]);
`ifdef HEX_LEADING_ZERO_BLANK_EN
      if (!nz && i > 0) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  // Scoreboard: every change of the display must match the next expected pattern.
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && hex_bus !== last_hex) begin
        last_hex = hex_bus;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got %h required no change", hex_bus);
        end else begin
          e = exp_q.pop_front();
          if (hex_bus !== e) $display("FAIL scoreboard_display: got %h required %h", hex_bus, e);
          else passed++;
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic we);
    @(negedge clk);
    mem_write  = we;
    alu_result = addr;
    write_data = data;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
    alu_result = 32'b0;
    $display("write addr=%h data=%0d we=%0b", addr, data, we);
  endtask

  task automatic check_status(input string name, input logic [31:0] expv);
    alu_result = STAT;
    #1;
    total++;
    if (rd_data !== expv) $display("FAIL %s: got %h required %h", name, rd_data, expv);
    else passed++;
    alu_result = 32'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    alu_result = STAT;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (rd_data[1:0] == 2'b00) done = 1'b1;
    end
    alu_result = 32'b0;
    total++;
    if (!done) $display("FAIL wait_done_timeout: got busy/pending %b required 00", rd_data[1:0]);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (hex_bus !== ALL_BLANK) $display("FAIL reset_hex: got %h required %h", hex_bus, ALL_BLANK);
    else passed++;
    check_status("reset_status", 32'h0);
    last_hex = ALL_BLANK;
    mon_en = 1'b1;
    $display("reset done hex=%h", hex_bus);
  endtask

  task automatic test_ignored();
    do_write(32'h0000_0408, 32'd123, 1'b1);
    check_status("ignored_wrong_addr", 32'h0);
    do_write(BASE, 32'd456, 1'b0);
    check_status("ignored_no_strobe", 32'h0);
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (hex_bus !== ALL_BLANK) $display("FAIL ignored_hex: got %h required %h", hex_bus, ALL_BLANK);
    else passed++;
  endtask

  task automatic test_basic();
    logic [48:0] old_hex;
    logic [48:0] new_hex;
    bool_loop: begin end
    old_hex = hex_bus;
    new_hex = disp_model(1234567);
    exp_q.push_back(new_hex);
    do_write(BASE, 32'd1234567, 1'b1);
    for (int c = 1; c <= 25; c++) begin
      alu_result = STAT;
      #1;
      total++;
      if (rd_data[0] !== 1'b1 || hex_bus !== old_hex)
        $display("FAIL basic_cycle%0d: got busy=%b hex=%h required busy=1 hex=%h",
                 c, rd_data[0], hex_bus, old_hex);
      else passed++;
      @(posedge clk);
      #1;
    end
    alu_result = STAT;
    #1;
    total++;
    if (rd_data[0] !== 1'b0 || hex_bus !== new_hex)
      $display("FAIL basic_cycle26: got busy=%b hex=%h required busy=0 hex=%h",
               rd_data[0], hex_bus, new_hex);
    else passed++;
    alu_result = 32'b0;
    $display("basic 1234567 hex=%h", hex_bus);
  endtask

  task automatic test_leading();
    exp_q.push_back(disp_model(42));
    do_write(BASE, 32'd42, 1'b1);
    wait_done();
    total++;
    if (hex_bus[13:0] !== {7'b0011001, 7'b0100100})
      $display("FAIL leading_low_digits: got %h required %h", hex_bus[13:0], {7'b0011001, 7'b0100100});
    else passed++;
    $display("value 42 hex=%h", hex_bus);
  endtask

  task automatic test_dash();
    exp_q.push_back(disp_model(10_000_000));
    do_write(BASE, 32'hAB00_0000 | 32'd10_000_000, 1'b1);
    wait_done();
    total++;
    if (hex_bus !== {7{7'b0111111}}) $display("FAIL dash_10M: got %h required %h", hex_bus, {7{7'b0111111}});
    else passed++;
    exp_q.push_back(disp_model(9_999_999));
    do_write(BASE, 32'd9_999_999, 1'b1);
    wait_done();
    total++;
    if (hex_bus !== {7{7'b0010000}}) $display("FAIL nines: got %h required %h", hex_bus, {7{7'b0010000}});
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(disp_model(11));
    do_write(BASE, 32'd11, 1'b1);
    repeat (3) @(posedge clk);
    do_write(BASE, 32'd22, 1'b1);
    @(posedge clk);
    exp_q.push_back(disp_model(33));
    do_write(BASE, 32'd33, 1'b1);
    check_status("b2b_status", 32'h3);
    wait_done();
    total++;
    if (hex_bus !== disp_model(33)) $display("FAIL b2b_final: got %h required %h", hex_bus, disp_model(33));
    else passed++;
  endtask

  task automatic test_reset_abort();
    do_write(BASE, 32'd555, 1'b1);
    repeat (9) @(posedge clk);
    exp_q.push_back(ALL_BLANK);
    @(negedge clk);
    reset      = 1'b1;
    mem_write  = 1'b1;
    alu_result = BASE;
    write_data = 32'd99;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_write  = 1'b0;
    alu_result = 32'b0;
    total++;
    if (hex_bus !== ALL_BLANK) $display("FAIL abort_hex: got %h required %h", hex_bus, ALL_BLANK);
    else passed++;
    check_status("abort_status", 32'h0);
    repeat (30) @(posedge clk);
    #1;
    check_status("abort_status_later", 32'h0);
    exp_q.push_back(disp_model(7));
    do_write(BASE, 32'd7, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    total++;
    if (hex_bus !== ALL_BLANK) $display("FAIL abort_early: got %h required %h", hex_bus, ALL_BLANK);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (hex_bus !== disp_model(7)) $display("FAIL abort_seven: got %h required %h", hex_bus, disp_model(7));
    else passed++;
    $display("after abort value 7 hex=%h", hex_bus);
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_basic();
    test_leading();
    test_dash();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
